// File: rtl/fifo_rd_stream.sv
// Read-side master for the synchronous FIFO: drains rden/dout/valid into a small
// local buffer and presents it as a valid/ready stream framed into PKT_LEN-word packets.
module fifo_rd_stream #(
  parameter int FIFO_DWTH = 8,
  parameter int RD_LAT    = 1,
  parameter int BUF_AW    = 2,
  parameter int PKT_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  input  logic [FIFO_DWTH-1:0] fifo_dout,
  input  logic                 fifo_valid,
  output logic [FIFO_DWTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 idle,
  output logic                 err
);

  // state | meaning
  // IDLE  | not fetching; nothing in flight
  // RUN   | issuing reads whenever a buffer slot is guaranteed
  // DRAIN | enable dropped; no new reads, finishing in-flight and buffered words
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int              DEPTH    = 2 ** BUF_AW;
  localparam int              CW       = BUF_AW + 2;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [BUF_AW:0] DEPTH_O  = (BUF_AW + 1)'(DEPTH);
  localparam logic [15:0]     LAST_CNT = 16'(PKT_LEN - 1);

  state_t               state;
  logic [RD_LAT-1:0]    inflight;
  logic [CW-1:0]        inflight_cnt;
  logic [BUF_AW:0]      occ;
  logic [BUF_AW-1:0]    wptr;
  logic [BUF_AW-1:0]    rptr;
  logic [FIFO_DWTH-1:0] mem [DEPTH];
  logic [15:0]          pkt_cnt;
  logic                 space_ok;
  logic                 buf_full;
  logic                 push;
  logic                 pop;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight_cnt = inflight_cnt + CW'(inflight[i]);
  end

  // Reserve a slot for every read already issued so back-pressure can never drop a word
  assign space_ok  = ({1'b0, occ} + inflight_cnt) < DEPTH_C;
  assign fifo_rden = (state == RUN) & enable & ~fifo_empty & space_ok;
  assign buf_full  = (occ == DEPTH_O);
  assign push      = fifo_valid & ~buf_full;
  assign m_valid   = (occ != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = mem[rptr];
  assign m_last    = m_valid & (pkt_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= RUN;
          idle  <= 1'b0;
        end
        RUN: if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (inflight_cnt == '0 && occ == '0) begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      occ      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      pkt_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      inflight[0] <= fifo_rden;
      for (int i = 1; i < RD_LAT; i++)
        inflight[i] <= inflight[i-1];
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (pop) pkt_cnt <= m_last ? 16'd0 : pkt_cnt + 16'd1;
      if (fifo_valid && (inflight_cnt == '0 || buf_full)) err <= 1'b1;
    end
  end

  // Buffer storage carries no reset; m_data is don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= fifo_dout;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO models with RD_LAT 1 and 3, a data/framing scoreboard,
// and directed sequences for streaming, back-pressure, empty gaps, drain, error and reset.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: RD_LAT=1
  logic       enable_a, fifo_empty_a, fifo_rden_a, fifo_valid_a;
  logic [7:0] fifo_dout_a, m_data_a;
  logic       m_valid_a, m_ready_a, m_last_a, idle_a, err_a;
  // instance B: RD_LAT=3
  logic       enable_b, fifo_empty_b, fifo_rden_b, fifo_valid_b;
  logic [7:0] fifo_dout_b, m_data_b;
  logic       m_valid_b, m_ready_b, m_last_b, idle_b, err_b;

  fifo_rd_stream #(.FIFO_DWTH(8), .RD_LAT(1), .BUF_AW(2), .PKT_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .fifo_empty(fifo_empty_a),
    .fifo_rden(fifo_rden_a), .fifo_dout(fifo_dout_a), .fifo_valid(fifo_valid_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a),
    .idle(idle_a), .err(err_a));

  fifo_rd_stream #(.FIFO_DWTH(8), .RD_LAT(3), .BUF_AW(2), .PKT_LEN(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .fifo_empty(fifo_empty_b),
    .fifo_rden(fifo_rden_b), .fifo_dout(fifo_dout_b), .fifo_valid(fifo_valid_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b),
    .idle(idle_b), .err(err_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO model A
  logic [7:0] fmem_a [256];
  int         fwr_a = 0;
  int         frd_a, iss_a, pop_a;
  logic       fv_a, spur_a;
  logic [7:0] fd_a;
  assign fifo_empty_a = (frd_a == fwr_a);
  assign fifo_valid_a = fv_a | spur_a;
  assign fifo_dout_a  = spur_a ? 8'hEE : fd_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frd_a <= 0; fv_a <= 1'b0; fd_a <= 8'h00; iss_a <= 0; pop_a <= 0;
    end else begin
      fv_a <= fifo_rden_a;
      fd_a <= fmem_a[frd_a % 256];
      if (fifo_rden_a) frd_a <= frd_a + 1;
      iss_a <= iss_a + int'(fifo_rden_a);
      pop_a <= pop_a + int'(m_valid_a & m_ready_a);
    end
  end

  // FIFO model B, three-stage read pipeline
  logic [7:0] fmem_b [256];
  int         fwr_b = 0;
  int         frd_b, iss_b, pop_b;
  logic       fvb [3];
  logic [7:0] fdb [3];
  assign fifo_empty_b = (frd_b == fwr_b);
  assign fifo_valid_b = fvb[2];
  assign fifo_dout_b  = fdb[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frd_b <= 0; iss_b <= 0; pop_b <= 0;
      for (int i = 0; i < 3; i++) begin fvb[i] <= 1'b0; fdb[i] <= 8'h00; end
    end else begin
      fvb[0] <= fifo_rden_b;
      fdb[0] <= fmem_b[frd_b % 256];
      for (int i = 1; i < 3; i++) begin fvb[i] <= fvb[i-1]; fdb[i] <= fdb[i-1]; end
      if (fifo_rden_b) frd_b <= frd_b + 1;
      iss_b <= iss_b + int'(fifo_rden_b);
      pop_b <= pop_b + int'(m_valid_b & m_ready_b);
    end
  end

  // Scoreboards
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         pk_a = 0;
  int         hs_n = 0, hs_first = 0, hs_last = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rden_a) begin
        chk("a_rden_while_empty", fifo_empty_a, 0);
        chk("a_rden_space", (iss_a - pop_a) < 4, 1);
      end
      if (fifo_rden_b) chk("b_rden_space", (iss_b - pop_b) < 4, 1);
      if (m_valid_a && m_ready_a) begin
        if (exp_a.size() == 0) chk("a_extra_word", 1, 0);
        else begin
          chk("a_data", m_data_a, exp_a.pop_front());
          chk("a_last", m_last_a, pk_a == 15);
          pk_a = (pk_a == 15) ? 0 : pk_a + 1;
        end
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
      end else if (!m_valid_a) begin
        if (m_last_a) chk("a_last_without_valid", m_last_a, 0);
      end
      if (m_valid_b && m_ready_b) begin
        if (exp_b.size() == 0) chk("b_extra_word", 1, 0);
        else chk("b_data", m_data_b, exp_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem_a[fwr_a % 256] = 8'(base + i);
      exp_a.push_back(8'(base + i));
      fwr_a++;
    end
  endtask

  task automatic wait_sb_a(input int budget, input string tag);
    int n = 0;
    while (exp_a.size() != 0 && n < budget) begin tick(); n++; end
    chk(tag, exp_a.size(), 0);
  endtask

  task automatic wait_idle_a(input int budget, input string tag);
    int n = 0;
    while (!idle_a && n < budget) begin tick(); n++; end
    chk(tag, idle_a, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, i0;
    rst_n = 1'b0;
    enable_a = 1'b0; m_ready_a = 1'b0; spur_a = 1'b0;
    enable_b = 1'b0; m_ready_b = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_last",  m_last_a, 0);
    chk("rst_rden",    fifo_rden_a, 0);
    chk("rst_idle",    idle_a, 1);
    chk("rst_err",     err_a, 0);
    rst_n = 1'b1;
    tick();

    // 1: streaming, 32 words, one per cycle
    load_a(8'h00, 32);
    m_ready_a = 1'b1;
    enable_a  = 1'b1;
    wait_sb_a(200, "t1_drain");
    chk("t1_count", hs_n, 32);
    chk("t1_throughput", hs_last - hs_first, 31);

    // 2: random back-pressure
    load_a(8'h20, 40);
    n = 0;
    while (exp_a.size() != 0 && n < 2000) begin
      m_ready_a = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready_a = 1'b1;
    wait_sb_a(50, "t2_drain");

    // 3: FIFO runs dry mid-stream, refilled 10 cycles later
    load_a(8'h60, 8);
    wait_sb_a(100, "t3_first_half");
    tick(); tick();
    chk("t3_valid_falls", m_valid_a, 0);
    repeat (10) tick();
    load_a(8'h68, 8);
    wait_sb_a(100, "t3_second_half");

    // 4: drain with 3 buffered and 1 in flight
    m_ready_a = 1'b0;
    load_a(8'h80, 8);
    n = 0;
    while ((iss_a - pop_a) != 4 && n < 50) begin tick(); n++; end
    chk("t4_fill", iss_a - pop_a, 4);
    enable_a = 1'b0;
    p0 = pop_a;
    i0 = iss_a;
    repeat (5) tick();
    chk("t4_no_reads_in_drain", iss_a - i0, 0);
    chk("t4_stalled_valid", m_valid_a, 1);
    chk("t4_not_idle", idle_a, 0);
    m_ready_a = 1'b1;
    wait_idle_a(50, "t4_idle");
    chk("t4_words_out", pop_a - p0, 4);
    enable_a = 1'b1;
    wait_sb_a(100, "t4_resume");
    chk("t4_err_clean", err_a, 0);

    // 5: RD_LAT=3 with stalled consumer issues exactly four reads
    for (int i = 0; i < 6; i++) begin
      fmem_b[fwr_b % 256] = 8'(i);
      exp_b.push_back(8'(i));
      fwr_b++;
    end
    enable_b = 1'b1;
    repeat (20) tick();
    chk("t5_reads", iss_b, 4);
    chk("t5_valid", m_valid_b, 1);
    m_ready_b = 1'b1;
    n = 0;
    while (exp_b.size() != 0 && n < 100) begin tick(); n++; end
    chk("t5_drain", exp_b.size(), 0);
    enable_b = 1'b0;
    n = 0;
    while (!idle_b && n < 50) begin tick(); n++; end
    chk("t5_idle", idle_b, 1);
    chk("t5_err_clean", err_b, 0);

    // 6: spurious strobe at IDLE, then reset mid-packet
    enable_a = 1'b0;
    wait_idle_a(50, "t6_idle");
    m_ready_a = 1'b0;
    exp_a.push_back(8'hEE);
    spur_a = 1'b1;
    tick();
    spur_a = 1'b0;
    chk("t6_err_set", err_a, 1);
    repeat (3) tick();
    chk("t6_err_sticky", err_a, 1);
    m_ready_a = 1'b1;
    enable_a  = 1'b1;
    load_a(8'hA0, 40);
    n = 0;
    while (pk_a != 5 && n < 200) begin tick(); n++; end
    chk("t6_mid_packet", pk_a, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid_a, 0);
    chk("t6_rst_idle",  idle_a, 1);
    chk("t6_rst_rden",  fifo_rden_a, 0);
    exp_a.delete();
    pk_a  = 0;
    fwr_a = 0;
    fwr_b = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_err_cleared", err_a, 0);
    load_a(8'h40, 16);
    wait_sb_a(100, "t6_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
